bcd_display_scan: RTL and testbench

Four-digit multiplexed seven-segment driver for the Nexys2 board display. Sits directly downstream of the cascaded `bcd_digit` counters and consumes their packed 4-bit digit outputs. It snapshots all four digits once per scan frame, so a frame never mixes old and new values. It then time-multiplexes the digits onto the shared active-low segment and anode lines, with optional leading-zero blanking and per-digit decimal points.

---
 rtl/bcd_display_scan.sv | 155 +++++++++++++++
 tb/tb_bcd_display_scan.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// bcd_display_scan
// Four-digit multiplexed seven-segment driver. All four BCD digits and their
// decimal-point enables are snapshotted once per scan frame, at the wrap into
// slot 0, so a frame never mixes old and new values. Segment, dp and anode
// lines are active-low and fully registered; they only change on scan ticks
// or reset. Optional leading-zero blanking darkens leading zero digits.

module bcd_display_scan #(
   parameter int REFRESH_DIV = 50000   // clk cycles per lit digit, >= 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_en,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   // Active-low segment pattern for a BCD nibble (g..a). Non-BCD values
   // light only segment g so a corrupt counter shows up as a dash.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
      case (v)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Prescaler and scan position
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       idx_next;
   logic             tick;
   logic             wrap;

   // Per-frame snapshot of the inputs
   logic [15:0]      shadow_digits_q, shadow_digits_d;
   logic [3:0]       shadow_dp_q, shadow_dp_d;

   // Registered display outputs
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;
   logic             frame_tick_q, frame_tick_d;

   // Source values for the slot being loaded on this tick
   logic [15:0]      src_digits;
   logic [3:0]       src_dp;
   logic [3:0]       sel_nibble;
   logic [3:0]       nib_zero;
   logic [3:0]       lz_mask;
   logic             slot_dark;

   assign tick     = (cnt_q == CNT_MAX);
   assign wrap     = tick && (idx_q == 2'd3);
   assign idx_next = idx_q + 2'd1;

   // On the wrap tick slot 0 must show the freshly sampled inputs, since the
   // shadow only takes them on that same edge.
   assign src_digits = wrap ? digits : shadow_digits_q;
   assign src_dp     = wrap ? dp_en  : shadow_dp_q;
   assign sel_nibble = src_digits[{idx_next, 2'b00} +: 4];

   // Zero detection per digit; an invalid nibble is not zero, so it stops
   // blanking of everything to its right.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_zero
         assign nib_zero[gi] = (src_digits[gi*4 +: 4] == 4'd0);
      end
   endgenerate

   // A digit is a leading zero when it and every digit to its left are zero.
   // The rightmost digit always stays lit so a value of 0 is still visible.
   assign lz_mask[3] = nib_zero[3];
   assign lz_mask[2] = &nib_zero[3:2];
   assign lz_mask[1] = &nib_zero[3:1];
   assign lz_mask[0] = 1'b0;

   assign slot_dark = blank_lz && lz_mask[idx_next];

   // Next-state: prescaler wrap, scan advance, snapshot and output decode
   always_comb begin
      cnt_d           = tick ? '0 : cnt_q + 1'b1;
      idx_d           = idx_q;
      shadow_digits_d = shadow_digits_q;
      shadow_dp_d     = shadow_dp_q;
      seg_d           = seg_q;
      dp_d            = dp_q;
      an_d            = an_q;
      frame_tick_d    = wrap;

      if (wrap) begin
         shadow_digits_d = digits;
         shadow_dp_d     = dp_en;
      end

      if (tick) begin
         idx_d = idx_next;
         if (slot_dark) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
         end else begin
            an_d  = ~(4'b0001 << idx_next);
            seg_d = bcd_to_seg(sel_nibble);
            dp_d  = ~src_dp[idx_next];
         end
      end
   end

   // State registers; reset darkens the display and restarts the frame so
   // the first tick wraps to slot 0
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q           <= '0;
         idx_q           <= 2'd3;
         shadow_digits_q <= '0;
         shadow_dp_q     <= '0;
         seg_q           <= 7'b1111111;
         dp_q            <= 1'b1;
         an_q            <= 4'b1111;
         frame_tick_q    <= 1'b0;
      end else begin
         cnt_q           <= cnt_d;
         idx_q           <= idx_d;
         shadow_digits_q <= shadow_digits_d;
         shadow_dp_q     <= shadow_dp_d;
         seg_q           <= seg_d;
         dp_q            <= dp_d;
         an_q            <= an_d;
         frame_tick_q    <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan
// Self-checking bench for bcd_display_scan with REFRESH_DIV = 4. A reference
// model derives the expected outputs from the number of edges since reset:
// slot changes every D edges, the slot number is (edges/D - 1) mod 4 and the
// inputs are captured whenever slot 0 begins.

module tb_bcd_display_scan;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp_en = 4'b0000;
   logic        blank_lz = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bcd_display_scan #(.REFRESH_DIV(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .digits     (digits),
      .dp_en      (dp_en),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   // Seven-segment table (g..a, active low); non-BCD shows a dash
   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Reference model
   int          m_n = 0;
   int          m_slot = -1;
   logic [15:0] m_snap = 16'h0000;
   logic [3:0]  m_snap_dp = 4'b0000;
   logic [3:0]  e_an = 4'b1111;
   logic [6:0]  e_seg = 7'b1111111;
   logic        e_dp = 1'b1;
   logic        e_ft = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_n = 0; m_slot = -1; m_snap = 16'h0000; m_snap_dp = 4'b0000;
         e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_ft = 1'b0;
      end else begin
         m_n  = m_n + 1;
         e_ft = 1'b0;
         if (m_n % D == 0) begin
            logic dark;
            m_slot = (m_n / D - 1) % 4;
            if (m_slot == 0) begin
               m_snap = digits; m_snap_dp = dp_en; e_ft = 1'b1;
            end
            dark = 1'b0;
            if (blank_lz && m_slot > 0) begin
               dark = 1'b1;
               for (int j = m_slot; j < 4; j++)
                  if (m_snap[4*j +: 4] != 4'd0) dark = 1'b0;
            end
            if (dark) begin
               e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
            end else begin
               e_an = 4'b1111;
               e_an[m_slot] = 1'b0;
               e_seg = ref_seg(m_snap[4*m_slot +: 4]);
               e_dp = ~m_snap_dp[m_slot];
            end
         end
      end
   end

   task automatic wait_slot(input int s);
      int guard = 0;
      @(negedge clk);
      while (m_slot != s && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      if (m_slot != s) begin
         n_checks++; n_fail++;
         $display("FAIL wait_slot timeout: slot=%0d required=%0d", m_slot, s);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; digits = 16'h1234; dp_en = 4'b0000; blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({an, seg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: an=%b seg=%b dp=%b ft=%b required an=1111 seg=1111111 dp=1 ft=0", an, seg, dp, frame_tick);
      end
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({an, seg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dark edge%0d: an=%b seg=%b dp=%b ft=%b required dark", k, an, seg, dp, frame_tick);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({an, seg, dp, frame_tick} !== {4'b1110, 7'b0011001, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_first_slot: an=%b seg=%b dp=%b ft=%b required an=1110 seg=0011001 dp=1 ft=1", an, seg, dp, frame_tick);
      end
      @(negedge clk);
      n_checks++;
      if (frame_tick !== 1'b0 || an !== 4'b1110) begin
         n_fail++;
         $display("FAIL reset_tick_pulse: an=%b ft=%b required an=1110 ft=0", an, frame_tick);
      end
      $display("test_reset done");
   endtask

   task automatic test_scan_order();
      logic [6:0] s_tab [4];
      logic [3:0] a_tab [4];
      s_tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
      a_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      for (int c = 0; c < 32; c++) begin
         if (c > 0) @(negedge clk);
         n_checks++;
         if (an !== a_tab[m_slot] || seg !== s_tab[m_slot] || dp !== 1'b1 ||
             frame_tick !== e_ft) begin
            n_fail++;
            $display("FAIL scan_order cyc%0d: an=%b seg=%b dp=%b ft=%b required an=%b seg=%b dp=1 ft=%b",
                     c, an, seg, dp, frame_tick, a_tab[m_slot], s_tab[m_slot], e_ft);
         end
      end
      $display("test_scan_order done");
   endtask

   task automatic test_snapshot();
      logic [6:0] old_tab [4];
      logic [6:0] new_tab [4];
      logic       seen_wrap;
      int         ft_count;
      logic [6:0] want;
      old_tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
      new_tab = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
      seen_wrap = 1'b0; ft_count = 0;
      wait_slot(1);
      digits = 16'h5678;
      for (int c = 0; c < 24; c++) begin
         if (c > 0) @(negedge clk);
         if (m_n % D == 0 && m_slot == 0) seen_wrap = 1'b1;
         if (frame_tick === 1'b1) ft_count++;
         want = seen_wrap ? new_tab[m_slot] : old_tab[m_slot];
         n_checks++;
         if (seg !== want || frame_tick !== (m_n % D == 0 && m_slot == 0)) begin
            n_fail++;
            $display("FAIL snapshot cyc%0d: seg=%b ft=%b required seg=%b ft=%b",
                     c, seg, frame_tick, want, (m_n % D == 0 && m_slot == 0));
         end
      end
      n_checks++;
      if (ft_count != 1) begin
         n_fail++;
         $display("FAIL snapshot_ft_count: got %0d required 1", ft_count);
      end
      $display("test_snapshot done");
   endtask

   task automatic test_blanking();
      logic [15:0] pats [3];
      int          dark_cnt;
      int          lit_cnt;
      pats = '{16'h0050, 16'h0000, 16'h0A00};
      for (int p = 0; p < 3; p++) begin
         wait_slot(3);
         digits = pats[p]; blank_lz = 1'b1; dp_en = 4'b0000;
         wait_slot(0);
         dark_cnt = 0; lit_cnt = 0;
         for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (an === 4'b1111) dark_cnt++; else lit_cnt++;
            n_checks++;
            if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft}) begin
               n_fail++;
               $display("FAIL blanking %h cyc%0d: an=%b seg=%b dp=%b ft=%b required an=%b seg=%b dp=%b ft=%b",
                        pats[p], c, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
            end
            if (p == 2 && m_slot == 2) begin
               n_checks++;
               if (an !== 4'b1011 || seg !== 7'b0111111) begin
                  n_fail++;
                  $display("FAIL blanking_dash: an=%b seg=%b required an=1011 seg=0111111", an, seg);
               end
            end
            if (p == 1 && m_slot == 0) begin
               n_checks++;
               if (an !== 4'b1110 || seg !== 7'b1000000) begin
                  n_fail++;
                  $display("FAIL blanking_zero: an=%b seg=%b required an=1110 seg=1000000", an, seg);
               end
            end
         end
         n_checks++;
         if ((p == 0 && dark_cnt != 8) || (p == 1 && lit_cnt != 4) || (p == 2 && dark_cnt != 4)) begin
            n_fail++;
            $display("FAIL blanking_dark_count %h: dark=%0d lit=%0d", pats[p], dark_cnt, lit_cnt);
         end
         $display("test_blanking pattern %h done", pats[p]);
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_decimal_point();
      wait_slot(3);
      dp_en = 4'b0100; digits = 16'h9999; blank_lz = 1'b0;
      wait_slot(0);
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         n_checks++;
         if (seg !== 7'b0010000 || dp !== (an === 4'b1011 ? 1'b0 : 1'b1) ||
             {an, dp} !== {e_an, e_dp}) begin
            n_fail++;
            $display("FAIL decimal_point cyc%0d: an=%b seg=%b dp=%b required an=%b seg=0010000 dp=%b",
                     c, an, seg, dp, e_an, e_dp);
         end
      end
      dp_en = 4'b0000;
      $display("test_decimal_point done");
   endtask

   task automatic test_mid_reset();
      digits = 16'h1234; dp_en = 4'b0000; blank_lz = 1'b0;
      wait_slot(2);
      n_checks++;
      if (an !== 4'b1011) begin
         n_fail++;
         $display("FAIL mid_reset_pre: an=%b required 1011", an);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({an, seg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_reset_values: an=%b seg=%b dp=%b ft=%b required dark", an, seg, dp, frame_tick);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({an, seg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_dark edge%0d: an=%b seg=%b dp=%b ft=%b", k, an, seg, dp, frame_tick);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({an, seg, dp, frame_tick} !== {4'b1110, 7'b0011001, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_reset_first_slot: an=%b seg=%b dp=%b ft=%b required an=1110 seg=0011001 dp=1 ft=1", an, seg, dp, frame_tick);
      end
      $display("test_mid_reset done");
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         n_checks++;
         if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft}) begin
            n_fail++;
            $display("FAIL random cyc%0d: an=%b seg=%b dp=%b ft=%b required an=%b seg=%b dp=%b ft=%b",
                     c, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
         end
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) begin
            for (int j = 0; j < 4; j++)
               digits[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            dp_en = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      end
      reset = 1'b0;
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_snapshot();
      test_blanking();
      test_decimal_point();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
